// File: rtl/pipe_addsub.sv
// pipe_addsub: W-bit two's-complement adder/subtractor. The carry chain is cut
// into STAGES chunks of CW = W/STAGES bits, with one register bank per chunk.
// Both sides use valid/ready handshakes, and the whole pipe advances together
// (adv = !out_valid || out_ready).
// Optional macro ADDSUB_SAT_EN: signed saturation of s on overflow.
// Each stage registers only the result bits it has already computed and the
// operand bits that no later stage has consumed yet. That is why the per-stage
// vector widths differ from stage to stage.
module pipe_addsub #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         k,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int CW = W / STAGES;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : st
            localparam int LO = g * CW;

            // xa/ya hold the operand bits still to be summed. y is already
            // inverted for subtraction. ca is the carry into this chunk.
            logic [W-1:LO]     xa;
            logic [W-1:LO]     ya;
            logic              ca;
            logic              va;
            logic [CW:0]       t;
            logic [LO+CW-1:0]  sn;

            assign t = {1'b0, xa[LO+CW-1:LO]} + {1'b0, ya[LO+CW-1:LO]} + {{CW{1'b0}}, ca};

            if (g == 0) begin : src
                assign xa = x;
                assign ya = y ^ {W{k}};
                assign ca = k;
                assign va = in_valid;
                assign sn = t[CW-1:0];
            end else begin : src
                assign xa = st[g-1].mid.xq;
                assign ya = st[g-1].mid.yq;
                assign ca = st[g-1].mid.cq;
                assign va = st[g-1].mid.vq;
                assign sn = {t[CW-1:0], st[g-1].mid.sq};
            end

            if (g < STAGES - 1) begin : mid
                logic [W-1:LO+CW]  xq;
                logic [W-1:LO+CW]  yq;
                logic [LO+CW-1:0]  sq;
                logic              cq;
                logic              vq;

                // Intermediate bank: capture chunk sum, carry and unconsumed operands on advance
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vq <= 1'b0;
                        cq <= 1'b0;
                        xq <= '0;
                        yq <= '0;
                        sq <= '0;
                    end else if (adv) begin
                        vq <= va;
                        cq <= t[CW];
                        xq <= xa[W-1:LO+CW];
                        yq <= ya[W-1:LO+CW];
                        sq <= sn;
                    end
                end
            end else begin : fin
                logic         cmsb;
                logic         ov;
                logic [W-1:0] res;

                // Recover the carry into the MSB from the sum bit and its two operand bits
                assign cmsb = sn[W-1] ^ xa[W-1] ^ ya[W-1];
                assign ov   = cmsb ^ t[CW];

`ifdef ADDSUB_SAT_EN
                assign res = ov ? (xa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sn;
`else
                assign res = sn;
`endif

                // Output bank: register result and flags, holding them while stalled
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid <= 1'b0;
                        s         <= '0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        zero      <= 1'b0;
                    end else if (adv) begin
                        out_valid <= va;
                        s         <= res;
                        cout      <= t[CW];
                        ovf       <= ov;
                        zero      <= (res == '0);
                    end
                end
            end
        end
    endgenerate

endmodule
